// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// default parameter values, also used by the downstream FIFO.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_D_WIDTH   = 8;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_STALL_MAX = 32;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority search: first set bit of eligible, starting at
// ptr+1 and wrapping modulo N. Purely combinational.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  // Walk the N candidates in rotating order; the first hit wins.
  always_comb begin
    int j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && eligible[j]) begin
        found = 1'b1;
        index = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst write arbiter: N requesters share one FIFO write port. A granted
// requester keeps the port for BURST_LEN beats, until it stalls for
// STALL_MAX counted cycles, or until its enable is removed.
//
// Handshake: a beat of requester i transfers in a cycle where
// req_valid[i] && req_ready[i]; that same cycle wr=1 carries the beat.
// req_ready never depends on req_valid, and wr never asserts while
// fifo_full is high.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int STALL_MAX = DEF_STALL_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       wr,
  output logic [D_WIDTH-1:0]         data_fifo,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       stall_abort
);

  localparam int IW = $clog2(N_REQ);

  state_t          state;
  logic [IW-1:0]   gid_q;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      beat_cnt;
  logic [7:0]      stall_cnt;
  logic            abort_q;

  logic [N_REQ-1:0]   eligible;
  logic               found;
  logic [IW-1:0]      pick;
  logic               owner_valid;
  logic               owner_en;
  logic [D_WIDTH-1:0] owner_data;
  logic               open_slot;
  logic               accept;
  logic               stall_tick;
  logic               last_beat;
  logic               stall_hit;

  assign eligible = req_valid & req_en;

  fifo_wr_arbiter_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .found    (found),
    .index    (pick)
  );

  assign owner_valid = req_valid[gid_q];
  assign owner_en    = req_en[gid_q];
  assign owner_data  = req_data[int'(gid_q)*D_WIDTH +: D_WIDTH];

  // The owner may transfer only while enabled and the FIFO has room; a
  // disabled owner is being released and transfers nothing.
  assign open_slot  = (state == BURST) && owner_en && !fifo_full;
  assign accept     = open_slot && owner_valid;
  assign stall_tick = open_slot && !owner_valid;

  // Counters are 8 bits; compare in 9 bits so BURST_LEN=256 works.
  assign last_beat = ({1'b0, beat_cnt} + 9'd1) == 9'(BURST_LEN);
  assign stall_hit = ({1'b0, stall_cnt} + 9'd1) == 9'(STALL_MAX);

  assign busy        = (state == BURST);
  assign grant_id    = gid_q;
  assign stall_abort = abort_q;
  assign wr          = accept;
  assign data_fifo   = accept ? owner_data : '0;

  // Only the owner's ready bit can be high.
  always_comb begin
    req_ready = '0;
    if (open_slot) req_ready[gid_q] = 1'b1;
  end

  // Grant/burst FSM with beat and stall counters and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gid_q     <= '0;
      rr_ptr    <= IW'(N_REQ - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gid_q     <= pick;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!owner_en) begin
            state  <= IDLE;
            rr_ptr <= gid_q;
          end else if (accept) begin
            stall_cnt <= '0;
            beat_cnt  <= beat_cnt + 8'd1;
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= gid_q;
            end
          end else if (stall_tick) begin
            if (stall_hit) begin
              state   <= IDLE;
              rr_ptr  <= gid_q;
              abort_q <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// all outputs compared each cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int D  = 8;
  localparam int N  = 4;
  localparam int BL = 16;
  localparam int SM = 32;
  localparam int IW = $clog2(N);
  localparam int VW = 3 + N + IW + D;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_en;
  logic [N-1:0]   req_valid;
  logic [N*D-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           wr;
  logic [D-1:0]   data_fifo;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic           stall_abort;

  fifo_wr_arbiter #(
    .D_WIDTH   (D),
    .N_REQ     (N),
    .BURST_LEN (BL),
    .STALL_MAX (SM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_en      (req_en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .wr          (wr),
    .data_fifo   (data_fifo),
    .grant_id    (grant_id),
    .busy        (busy),
    .stall_abort (stall_abort)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the port, how far into the burst it is.
  bit m_busy, m_abort;
  int m_gid, m_beats, m_stalls, m_ptr;

  logic [N-1:0]  e_ready;
  logic          e_wr;
  logic [D-1:0]  e_data;
  logic [VW-1:0] e_vec, a_vec;
  logic [IW-1:0] exp_q[$];

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_gid = 0; m_beats = 0; m_stalls = 0; m_ptr = N - 1;
  endtask

  // Expected outputs for the current inputs, plus the observed vector.
  task automatic model_comb();
    logic [IW-1:0] g;
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (m_busy && req_en[m_gid] && !fifo_full) e_ready[m_gid] = 1'b1;
    if (e_ready[m_gid] && req_valid[m_gid]) begin
      e_wr   = 1'b1;
      e_data = req_data[m_gid*D +: D];
    end
    g = m_gid[IW-1:0];
    e_vec = {e_wr, m_busy, m_abort, e_ready, g, e_data};
    a_vec = {wr, busy, stall_abort, req_ready, grant_id, data_fifo};
  endtask

  // Advance the model across one rising edge.
  task automatic model_clock();
    bit ab = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_ptr + k) % N;
        if (!m_busy && req_valid[idx] && req_en[idx]) begin
          m_busy = 1; m_gid = idx; m_beats = 0; m_stalls = 0;
        end
      end
    end else if (!req_en[m_gid]) begin
      m_busy = 0; m_ptr = m_gid;
    end else if (!fifo_full) begin
      if (req_valid[m_gid]) begin
        m_beats++; m_stalls = 0;
        if (m_beats == BL) begin m_busy = 0; m_ptr = m_gid; end
      end else begin
        m_stalls++;
        if (m_stalls == SM) begin m_busy = 0; m_ptr = m_gid; ab = 1; end
      end
    end
    m_abort = ab;
  endtask

  // Driver: reset pulse; starts and ends on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_data();
    req_data = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    req_en = '1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if ({wr, busy, stall_abort, req_ready, grant_id, data_fifo} !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: got %h want 0", c,
                 {wr, busy, stall_abort, req_ready, grant_id, data_fifo});
      end
      @(negedge clk);
    end
    model_reset();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec || wr !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      model_clock();
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int run_len = 0, gap = 0, runs = 0;
    logic prev_wr = 1'b0;
    logic [IW-1:0] want;
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    req_en = '1; req_valid = '1; fifo_full = 1'b0;
    do_reset();
    for (int c = 0; c < 90; c++) begin
      rand_data();
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL rr_cycle cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (wr) begin
        if (!prev_wr) begin
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tests++;
            if (grant_id !== want) begin
              fails++; $display("FAIL rr_order run %0d: got %0d want %0d", runs, grant_id, want);
            end
          end
          if (runs > 0) begin
            tests++;
            if (gap != 1) begin
              fails++; $display("FAIL rr_gap run %0d: got %0d want 1", runs, gap);
            end
          end
          run_len = 0;
        end
        run_len++; gap = 0;
      end else begin
        if (prev_wr) begin
          runs++;
          tests++;
          if (run_len != BL) begin
            fails++; $display("FAIL rr_len run %0d: got %0d want %0d", runs, run_len, BL);
          end
        end
        gap++;
      end
      prev_wr = wr;
      model_clock();
      @(negedge clk);
    end
    tests++;
    if (runs < 5 || exp_q.size() != 0) begin
      fails++; $display("FAIL rr_runs: got %0d runs, %0d unmatched want 5, 0", runs, exp_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int wcount = 0, full_cnt = 0, aborts = 0;
    req_en = '1; req_valid = 4'b0100; fifo_full = 1'b0;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      rand_data();
      fifo_full = (wcount == 7 && full_cnt < 5);
      if (fifo_full) full_cnt++;
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL full_cycle cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (fifo_full) begin
        tests++;
        if (wr !== 1'b0 || req_ready[2] !== 1'b0) begin
          fails++; $display("FAIL full_block cyc %0d: got wr=%b rdy=%b want 0 0", c, wr, req_ready[2]);
        end
      end
      if (wr) wcount++;
      if (stall_abort) aborts++;
      model_clock();
      @(negedge clk);
    end
    fifo_full = 1'b0;
    tests++;
    if (wcount != BL || aborts != 0) begin
      fails++; $display("FAIL full_total: got %0d writes %0d aborts want %0d 0", wcount, aborts, BL);
    end
  endtask

  task automatic test_stall_abort();
    int wcount = 0, aborts = 0;
    bit seen2 = 0;
    req_en = '1; req_valid = 4'b0010; fifo_full = 1'b0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      rand_data();
      req_valid[1] = (wcount < 3);
      req_valid[2] = (wcount >= 1);
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL stall_cycle cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (wr) wcount++;
      if (stall_abort) aborts++;
      if (busy && grant_id == 2) seen2 = 1;
      model_clock();
      @(negedge clk);
    end
    tests++;
    if (aborts != 1 || !seen2) begin
      fails++; $display("FAIL stall_result: got %0d aborts grant2=%0d want 1 1", aborts, seen2);
    end
  endtask

  task automatic test_enable();
    int wcount = 0;
    logic prev_wr = 1'b0;
    logic [IW-1:0] want;
    logic [IW-1:0] after_drop = '1;
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    req_en = 4'b0101; req_valid = '1; fifo_full = 1'b0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      rand_data();
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL en_cycle cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (wr && !prev_wr && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        tests++;
        if (grant_id !== want) begin
          fails++; $display("FAIL en_alternate cyc %0d: got %0d want %0d", c, grant_id, want);
        end
      end
      prev_wr = wr;
      model_clock();
      @(negedge clk);
    end
    // Drop requester 0's enable mid-burst.
    do_reset();
    prev_wr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      rand_data();
      if (wcount == 5) req_en[0] = 1'b0;
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL en_drop cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (wr && !prev_wr && wcount >= 5 && after_drop === '1) after_drop = grant_id;
      if (wr) wcount++;
      prev_wr = wr;
      model_clock();
      @(negedge clk);
    end
    tests++;
    if (after_drop !== 2'd2) begin
      fails++; $display("FAIL en_regrant: got %0d want 2", after_drop);
    end
  endtask

  task automatic test_reset_mid_burst();
    int wcount = 0, post = 0;
    logic [IW-1:0] first_gid = '1;
    req_en = '1; req_valid = '1; fifo_full = 1'b0;
    do_reset();
    // Run into the first burst, then reset asynchronously between edges.
    for (int c = 0; c < 12 && wcount < 9; c++) begin
      rand_data();
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL mid_pre cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (wr) wcount++;
      model_clock();
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({wr, busy, stall_abort, req_ready, grant_id, data_fifo} !== '0) begin
      fails++;
      $display("FAIL mid_async: got %h want 0", {wr, busy, stall_abort, req_ready, grant_id, data_fifo});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 18; c++) begin
      rand_data();
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; $display("FAIL mid_post cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      if (wr && first_gid === '1) first_gid = grant_id;
      if (wr) post++;
      model_clock();
      @(negedge clk);
    end
    tests++;
    if (first_gid !== 2'd0 || post != BL) begin
      fails++; $display("FAIL mid_fresh: got gid %0d %0d beats want 0 %0d", first_gid, post, BL);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rand_data();
      req_en    = ~(N'($urandom) & N'($urandom) & N'($urandom));
      fifo_full = ($urandom_range(0, 3) == 0);
      if (c < 1000) req_valid = N'($urandom) | N'($urandom);
      else          req_valid = N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 200) == 0) req_en = '1;
      #1 model_comb();
      tests++;
      if (a_vec !== e_vec) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL random cyc %0d: got %h want %h", c, a_vec, e_vec);
      end
      model_clock();
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_en = '0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_fifo_full();
    test_stall_abort();
    test_enable();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the run is a fixed number of cycles; never let it hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, pixel data width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter BURST_LEN, default 16, beats per granted burst (1..256).
REQ-004 SHALL have parameter STALL_MAX, default 32, idle cycles tolerated inside a burst before forced release (1..255).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port req_en  input  N_REQ  per-requester enable mask; 0 excludes that requester from arbitration.
REQ-009 SHALL have port req_valid  input  N_REQ  requester i offers a beat.
REQ-010 SHALL have port req_data  input  N_REQ*D_WIDTH  beat data; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-011 SHALL have port req_ready  output  N_REQ  beat of requester i accepted this cycle when req_valid[i] is also 1.
REQ-012 SHALL have port fifo_full  input  1  downstream FIFO full.
REQ-013 SHALL have port wr  output  1  FIFO write strobe.
REQ-014 SHALL have port data_fifo  output  D_WIDTH  FIFO write data.
REQ-015 SHALL have port grant_id  output  $clog2(N_REQ)  index of the current owner; valid while busy.
REQ-016 SHALL have port busy  output  1  a burst is in progress.
REQ-017 SHALL have port stall_abort  output  1  one-cycle pulse when a burst is force-released by timeout.

Function
REQ-018 SHALL implement FSM states IDLE and BURST.
REQ-019 IDLE: eligible = req_valid & req_en; if nonzero, SHALL grant the first eligible index searching from rr_ptr+1 upward modulo N_REQ, register grant_id, clear beat and stall counters, enter BURST next cycle.
REQ-020 IDLE: req_ready SHALL be all zero and wr SHALL be 0.
REQ-021 BURST: req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits 0.
REQ-022 BURST: wr SHALL equal req_valid[grant_id] & !fifo_full, combinationally (zero latency); data_fifo SHALL equal req_data slice of grant_id.
REQ-023 wr SHALL never assert while fifo_full is 1.
REQ-024 Each accepted beat SHALL increment an 8-bit beat counter; on the accept of beat BURST_LEN the FSM SHALL return to IDLE and set rr_ptr to grant_id.
REQ-025 BURST: a cycle with req_valid[grant_id]=0 SHALL increment the stall counter; a cycle with fifo_full=1 SHALL NOT count; any accepted beat SHALL clear it.
REQ-026 When the stall counter reaches STALL_MAX, the FSM SHALL return to IDLE, pulse stall_abort for one cycle, and set rr_ptr to grant_id.
REQ-027 Clearing req_en[grant_id] during BURST SHALL release the grant at the end of that cycle with no stall_abort; no beat is accepted in that cycle.
REQ-028 Arbitration SHALL NOT occur in the cycle a burst ends; earliest new grant is the following IDLE cycle (one idle bubble per burst).
REQ-029 data_fifo SHALL be driven to all zeros whenever wr is 0.

Reset
REQ-030 On rst=1 the FSM SHALL enter IDLE, rr_ptr SHALL be N_REQ-1 (so requester 0 wins first), counters SHALL clear.
REQ-031 During and after reset, until the first grant: wr=0, req_ready=0, busy=0, grant_id=0, stall_abort=0, data_fifo=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst immediately; no partial-burst state persists.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the parameter defaults (D_WIDTH, N_REQ, BURST_LEN, STALL_MAX), shared with the FIFO.
REQ-034 The round-robin priority search SHALL be a separate combinational sub-module rr_pick (inputs eligible mask and rr_ptr; outputs found and index).

Verification
REQ-035 Reset release, all req_valid=0 -> wr=0, busy=0, req_ready=0 for 20 cycles.
REQ-036 req_valid=4'b1111, req_en=4'b1111, fifo_full=0 -> grants 0,1,2,3,0 in order, each exactly 16 consecutive wr pulses, one idle cycle between bursts.
REQ-037 Requester 2 granted, fifo_full=1 held for 5 cycles at beat 7 -> wr=0 and req_ready[2]=0 those cycles, no stall_abort, burst completes with 16 writes total.
REQ-038 Requester 1 granted, drops req_valid after beat 3 for 32 cycles -> stall_abort pulses once, busy falls, next grant goes to requester 2 if valid.
REQ-039 req_en=4'b0101, all valid -> only requesters 0 and 2 ever granted, alternating; req_en[0] cleared mid-burst of 0 -> release next cycle, requester 2 granted.
REQ-040 rst asserted at beat 9 of a burst -> outputs zero asynchronously; after release requester 0 granted first with a fresh 16-beat burst.
